// File: rtl/seg7_pkg.sv
// Shared 7-segment code table and decoder state encoding.
// Both the hex encoder and seg7_scan_decoder import this table.
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}. A segment is lit when its bit is 0.
  localparam logic [6:0] SEG7_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG7_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG7_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG7_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG7_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG7_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG7_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG7_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG7_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG7_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG7_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG7_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG7_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG7_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG7_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG7_HEX_F = 7'b0111000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } seg7_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational reverse lookup: active-low segment pattern to {hit, nibble}.
module seg7_to_bin
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output seg7_dec_t  dec
);

  always_comb begin
    dec.hit = 1'b1;
    dec.nib = 4'h0;
    case (seg_n)
      SEG7_HEX_0: dec.nib = 4'h0;
      SEG7_HEX_1: dec.nib = 4'h1;
      SEG7_HEX_2: dec.nib = 4'h2;
      SEG7_HEX_3: dec.nib = 4'h3;
      SEG7_HEX_4: dec.nib = 4'h4;
      SEG7_HEX_5: dec.nib = 4'h5;
      SEG7_HEX_6: dec.nib = 4'h6;
      SEG7_HEX_7: dec.nib = 4'h7;
      SEG7_HEX_8: dec.nib = 4'h8;
      SEG7_HEX_9: dec.nib = 4'h9;
      SEG7_HEX_A: dec.nib = 4'hA;
      SEG7_HEX_B: dec.nib = 4'hB;
      SEG7_HEX_C: dec.nib = 4'hC;
      SEG7_HEX_D: dec.nib = 4'hD;
      SEG7_HEX_E: dec.nib = 4'hE;
      SEG7_HEX_F: dec.nib = 4'hF;
      default:    dec.hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus and stores each stable digit.
// Optional SEG7_BLANK_DETECT_EN: all-off pattern clears a digit instead of flagging err.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [IW-1:0]           upd_idx,
  output logic                    err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  seg7_state_e                   state;
  logic [NUM_DIGITS+6:0]         smp;
  logic [CW-1:0]                 cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0][3:0]    dig;
  logic [NUM_DIGITS-1:0]         vld;

  logic [NUM_DIGITS+6:0]         cur;
  logic [NUM_DIGITS-1:0]         sel;
  logic                          same, onehot, blank;
  logic [IW-1:0]                 idx;
  seg7_dec_t                     dec;

  assign cur    = {an_n, seg_n};
  assign same   = (cur == smp);
  assign sel    = ~an_n;
  assign onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

  // Count of consecutive repeats of the incoming sample, saturating.
  always_comb begin
    cnt_nxt = '0;
    if (same) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel[i]) idx = IW'(i);
  end

`ifdef SEG7_BLANK_DETECT_EN
  assign blank = (seg_n == SEG7_BLANK);
`else
  assign blank = 1'b0;
`endif

  seg7_to_bin u_dec (
    .seg_n (seg_n),
    .dec   (dec)
  );

  // A commit lands on the edge whose sample makes the repeat count reach its max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      smp     <= '1;
      cnt     <= '0;
      dig     <= '0;
      vld     <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      err     <= 1'b0;
    end else begin
      smp <= cur;
      cnt <= cnt_nxt;
      upd <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (onehot) state <= TRACK;
        end
        TRACK: begin
          if (!onehot) begin
            state <= IDLE;
          end else if (cnt_nxt == CNT_MAX) begin
            state   <= HOLD;
            upd     <= 1'b1;
            upd_idx <= idx;
            if (dec.hit) begin
              dig[idx] <= dec.nib;
              vld[idx] <= 1'b1;
            end else if (blank) begin
              dig[idx] <= 4'h0;
              vld[idx] <= 1'b0;
            end else begin
              vld[idx] <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!same) state <= onehot ? TRACK : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digits      = dig;
  assign digit_valid = vld;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with an expected-commit scoreboard.
module tb_seg7_scan_decoder;

  logic        clk, rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        err;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          at;
    int          idx;
    logic        err;
    logic [15:0] dig;
    logic [3:0]  vld;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] mdig;
  logic [3:0]  mvld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference table written out as seg pattern -> value, independent of the RTL package.
  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h10; 7'b1001111: return 5'h11;
      7'b0010010: return 5'h12; 7'b0000110: return 5'h13;
      7'b1001100: return 5'h14; 7'b0100100: return 5'h15;
      7'b0100000: return 5'h16; 7'b0001111: return 5'h17;
      7'b0000000: return 5'h18; 7'b0000100: return 5'h19;
      7'b0001000: return 5'h1A; 7'b1100000: return 5'h1B;
      7'b0110001: return 5'h1C; 7'b1000010: return 5'h1D;
      7'b0110000: return 5'h1E; 7'b0111000: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // Drive one pattern for n edges; at>0 means a commit is expected on edge 'at'.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n, input int at);
    exp_t e;
    logic [4:0] d;
    int i;
    an_n  = an;
    seg_n = seg;
    if (at > 0) begin
      i = 0;
      for (int k = 0; k < 4; k++) if (!an[k]) i = k;
      d = ref_dec(seg);
      e.err = 1'b0;
      if (d[4]) begin
        mdig[4*i +: 4] = d[3:0];
        mvld[i] = 1'b1;
      end else begin
        mvld[i] = 1'b0;
`ifdef SEG7_BLANK_DETECT_EN
        if (seg == 7'h7F) mdig[4*i +: 4] = 4'h0;
        else e.err = 1'b1;
`else
        e.err = 1'b1;
`endif
      end
      e.at = at; e.idx = i; e.dig = mdig; e.vld = mvld;
      sbq.push_back(e);
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (upd) begin
        if (sbq.size() == 0) begin
          chk("spurious_upd", 32'(k), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("upd_edge", 32'(k), 32'(e.at));
          chk("upd_idx", 32'(upd_idx), 32'(e.idx));
          chk("err", 32'(err), 32'(e.err));
          chk("digits_at_upd", 32'(digits), 32'(e.dig));
          chk("valid_at_upd", 32'(digit_valid), 32'(e.vld));
        end
      end else if (err) begin
        chk("err_without_upd", 32'(err), 32'(0));
      end
    end
    chk("missing_upd", 32'(sbq.size()), 32'(0));
    sbq.delete();
    chk("digits_end", 32'(digits), 32'(mdig));
    chk("valid_end", 32'(digit_valid), 32'(mvld));
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    mdig  = '0;
    mvld  = '0;
    #12;
    chk("rst_digits", 32'(digits), 32'(0));
    chk("rst_valid", 32'(digit_valid), 32'(0));
    chk("rst_upd", 32'(upd), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_idx", 32'(upd_idx), 32'(0));
    rst_n = 1'b1;

    // First digit after reset: commit on the 4th edge.
    hold(4'b1110, 7'b0010010, 4, 4);
    chk("first_digit0", 32'(digits[3:0]), 32'(2));

    // Scan all four digits.
    hold(4'b1110, 7'b1001111, 6, 4);
    hold(4'b1101, 7'b0001000, 6, 4);
    hold(4'b1011, 7'b1100000, 6, 4);
    hold(4'b0111, 7'b0111000, 6, 4);
    chk("scan_digits", 32'(digits), 32'h0000FBA1);
    chk("scan_valid", 32'(digit_valid), 32'hF);

    // Glitch mid-count restarts stability.
    hold(4'b1101, 7'b0000110, 2, 0);
    hold(4'b1101, 7'b0000111, 1, 0);
    hold(4'b1101, 7'b0000110, 4, 4);
    chk("glitch_digit1", 32'(digits[7:4]), 32'(3));

    // Unmapped pattern on digit 2.
    hold(4'b1011, 7'b1010101, 5, 4);
    chk("unmapped_digit2_kept", 32'(digits[11:8]), 32'hB);

    // Two digits selected: nothing commits.
    hold(4'b0011, 7'b0000000, 10, 0);

    // Same digit after another digit commits again.
    hold(4'b1110, 7'b0001111, 5, 4);
    hold(4'b1110, 7'b1111111, 4, 4);

    // Reset mid-HOLD acts without a clock edge.
    hold(4'b1110, 7'b0000001, 5, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits), 32'(0));
    chk("async_rst_valid", 32'(digit_valid), 32'(0));
    chk("async_rst_upd", 32'(upd), 32'(0));
    chk("async_rst_err", 32'(err), 32'(0));
    mdig = '0;
    mvld = '0;
    #3;
    rst_n = 1'b1;
    hold(4'b1110, 7'b0000001, 5, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
